// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types and constants for the camera capture sequencer
// Holds the FSM state encoding, the default frame geometry with its
// decimated output size, and the RGB565 pixel type.
package cam_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int DECIM_DEF    = 16;

    // Decimated output frame size for the default geometry.
    localparam int OUT_W = H_ACTIVE_DEF / DECIM_DEF;
    localparam int OUT_H = V_ACTIVE_DEF / DECIM_DEF;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ARM     = 3'd1;
    localparam state_t ST_VBLANK  = 3'd2;
    localparam state_t ST_CAPTURE = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/cam_byte_packer.sv
// rtl/cam_byte_packer.sv - pairs camera bytes into 16-bit pixels
// Ports:
//   clk, resetn  - pixel clock, synchronous active-low reset
//   en           - packing enabled; low clears the byte phase and hi latch
//   href, dat    - registered camera line-valid and byte
//   phase        - 1 when the high byte of a pixel is held
//   pix_valid    - high in the cycle the second byte is on dat
//   pix          - {first byte, second byte}, valid with pix_valid
module cam_byte_packer
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       en,
    input  logic       href,
    input  logic [7:0] dat,
    output logic       phase,
    output logic       pix_valid,
    output rgb565_t    pix
);

    logic [7:0] hi;

    always_ff @(posedge clk) begin
        if (!resetn || !en) begin
            phase <= 1'b0;
            hi    <= 8'd0;
        end else if (href) begin
            phase <= ~phase;
            if (!phase) begin
                hi <= dat;
            end
        end
    end

    assign pix_valid = en & href & phase;
    assign pix       = {hi, dat};

endmodule

// File: rtl/cam_capture_ctrl.sv
// rtl/cam_capture_ctrl.sv - frame-grab sequencer with decimated scratchpad writes
// Ports:
//   clk, resetn          - camera pixel clock, synchronous active-low reset
//   start, abort         - one-cycle control pulses (abort wins)
//   cam_vsync/href/dat   - IO-registered camera pins
//   wr_en/addr/data      - scratchpad write port, one RGB565 word per kept pixel
//   busy                 - ARM, VBLANK or CAPTURE
//   frame_done           - one-cycle pulse when a capture ends
//   err                  - sticky short-frame / odd-byte-line flag
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DECIM    = 16,
    parameter int ADDR_W   = 11
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_dat,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);

    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);

    state_t            state;
    logic              vs_q;
    logic              hr_q;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] ptr;

    logic    vs_rise;
    logic    vs_fall;
    logic    hr_fall;
    logic    keep;
    logic    phase;
    logic    pix_valid;
    rgb565_t pix;

    assign vs_rise = cam_vsync & ~vs_q;
    assign vs_fall = ~cam_vsync & vs_q;
    assign hr_fall = ~cam_href & hr_q;

    // Decimation grid; col saturates at H_ACTIVE so overlong lines write nothing.
    assign keep = ((int'(col) % DECIM) == 0) && ((int'(row) % DECIM) == 0)
                  && (int'(col) < H_ACTIVE);

    // Packer is held cleared outside CAPTURE and on every line end, which
    // discards a dangling odd byte.
    cam_byte_packer u_packer (
        .clk       (clk),
        .resetn    (resetn),
        .en        ((state == ST_CAPTURE) && !hr_fall),
        .href      (cam_href),
        .dat       (cam_dat),
        .phase     (phase),
        .pix_valid (pix_valid),
        .pix       (pix)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            vs_q    <= 1'b0;
            hr_q    <= 1'b0;
            col     <= '0;
            row     <= '0;
            ptr     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 16'd0;
            err     <= 1'b0;
        end else begin
            vs_q  <= cam_vsync;
            hr_q  <= cam_href;
            wr_en <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state   <= ST_ARM;
                            err     <= 1'b0;
                            col     <= '0;
                            row     <= '0;
                            ptr     <= '0;
                            wr_addr <= '0;
                        end
                    end
                    ST_ARM: begin
                        // Waiting for a rising vsync skips any partial frame.
                        if (vs_rise) begin
                            state <= ST_VBLANK;
                        end
                    end
                    ST_VBLANK: begin
                        if (vs_fall) begin
                            state <= ST_CAPTURE;
                            row   <= '0;
                            col   <= '0;
                        end
                    end
                    ST_CAPTURE: begin
                        if (pix_valid) begin
                            if (keep) begin
                                wr_en   <= 1'b1;
                                wr_data <= pix;
                                wr_addr <= ptr;
                                ptr     <= ptr + 1'b1;
                            end
                            if (int'(col) < H_ACTIVE) begin
                                col <= col + 1'b1;
                            end
                        end
                        // Line end is resolved before a coincident vsync rise,
                        // so a frame completing on that cycle is not an error.
                        if (hr_fall) begin
                            row <= row + 1'b1;
                            col <= '0;
                            if (phase) begin
                                err <= 1'b1;
                            end
                            if (int'(row) + 1 == V_ACTIVE) begin
                                state <= ST_DONE;
                            end else if (vs_rise) begin
                                err   <= 1'b1;
                                state <= ST_DONE;
                            end
                        end else if (vs_rise) begin
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy       = (state == ST_ARM) || (state == ST_VBLANK) || (state == ST_CAPTURE);
    assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb/tb_cam_capture_ctrl.sv - self-checking bench for cam_capture_ctrl (DECIM=2 and DECIM=1)
module tb_cam_capture_ctrl;

    localparam int H = 8;
    localparam int V = 4;

    logic       clk = 1'b0;
    logic       resetn, start, abort, cam_vsync, cam_href;
    logic [7:0] cam_dat;

    logic        wr_en2, busy2, fd2, err2;
    logic [2:0]  wr_addr2;
    logic [15:0] wr_data2;
    logic        wr_en1, busy1, fd1, err1;
    logic [4:0]  wr_addr1;
    logic [15:0] wr_data1;

    cam_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(2), .ADDR_W(3)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_dat(cam_dat),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .busy(busy2), .frame_done(fd2), .err(err2)
    );

    cam_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .ADDR_W(5)) dut1 (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_dat(cam_dat),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .busy(busy1), .frame_done(fd1), .err(err1)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int total = 0;
    int bad   = 0;

    // Write monitors
    int q2a[$], q2d[$], q1a[$], q1d[$], q1t[$];
    int done2 = 0, done1 = 0;

    always @(negedge clk) begin
        if (wr_en2 === 1'b1) begin
            q2a.push_back(int'(wr_addr2));
            q2d.push_back(int'(wr_data2));
        end
        if (wr_en1 === 1'b1) begin
            q1a.push_back(int'(wr_addr1));
            q1d.push_back(int'(wr_data1));
            q1t.push_back(cyc_n);
        end
        if (fd2 === 1'b1) done2++;
        if (fd1 === 1'b1) done1++;
    end

    // Frame under test
    logic [7:0] fb [0:7][0:15];
    int         llen [0:7];
    int         nlines;

    // Reference expectations
    int e_d[$], e_r[$];
    int e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gen(input int nl, input bit ramp);
        nlines = nl;
        for (int l = 0; l < 8; l++) begin
            llen[l] = 2 * H;
            for (int b = 0; b < 16; b++) fb[l][b] = ramp ? 8'(b) : 8'($urandom);
        end
    endtask

    task automatic play_line(input int l);
        for (int b = 0; b < llen[l]; b++) begin
            cam_href = 1'b1;
            cam_dat  = fb[l][b];
            cyc(1);
        end
        cam_href = 1'b0;
        cam_dat  = 8'd0;
        cyc(3);
    endtask

    task automatic play_lines(input int from);
        for (int l = from; l < nlines; l++) play_line(l);
    endtask

    task automatic vs_pulse();
        cam_vsync = 1'b1;
        cyc(4);
        cam_vsync = 1'b0;
        cyc(2);
    endtask

    task automatic play_frame();
        vs_pulse();
        play_lines(0);
        vs_pulse();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic clear_mon();
        q2a.delete(); q2d.delete(); q1a.delete(); q1d.delete(); q1t.delete();
        done2 = 0;
        done1 = 0;
    endtask

    // Expected writes: every d-th full pixel (at most H per line) of every d-th
    // captured line, in raster order. Error on any odd line or a frame that
    // ended early (unless the capture was aborted).
    task automatic build_exp(input int d, input int rows, input bit aborted);
        e_d.delete();
        e_r.delete();
        e_err = (!aborted && rows < V) ? 1 : 0;
        for (int r = 0; r < rows; r++) begin
            if (llen[r] % 2 != 0) e_err = 1;
            if (r % d == 0) begin
                for (int k = 0; k < llen[r] / 2 && k < H; k++) begin
                    if (k % d == 0) begin
                        e_d.push_back(int'({fb[r][2*k], fb[r][2*k+1]}));
                        e_r.push_back(r);
                    end
                end
            end
        end
    endtask

    task automatic check_frame(input string tag, input int rows, input bit aborted);
        cyc(4);
        build_exp(2, rows, aborted);
        chk($sformatf("%s/d2_count", tag), q2d.size(), e_d.size());
        for (int i = 0; i < e_d.size(); i++) begin
            if (i < q2d.size()) begin
                chk($sformatf("%s/d2_data%0d", tag, i), q2d[i], e_d[i]);
                chk($sformatf("%s/d2_addr%0d", tag, i), q2a[i], i);
            end
        end
        chk($sformatf("%s/d2_err", tag), err2, e_err);
        chk($sformatf("%s/d2_done", tag), done2, aborted ? 0 : 1);
        chk($sformatf("%s/d2_busy", tag), busy2, 0);
        build_exp(1, rows, aborted);
        chk($sformatf("%s/d1_count", tag), q1d.size(), e_d.size());
        for (int i = 0; i < e_d.size(); i++) begin
            if (i < q1d.size()) begin
                chk($sformatf("%s/d1_data%0d", tag, i), q1d[i], e_d[i]);
                chk($sformatf("%s/d1_addr%0d", tag, i), q1a[i], i);
                if (i > 0 && e_r[i] == e_r[i-1])
                    chk($sformatf("%s/d1_gap%0d", tag, i), q1t[i] - q1t[i-1], 2);
            end
        end
        chk($sformatf("%s/d1_err", tag), err1, e_err);
        chk($sformatf("%s/d1_done", tag), done1, aborted ? 0 : 1);
        chk($sformatf("%s/d1_busy", tag), busy1, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk($sformatf("%s/wr_en", tag), {wr_en2, wr_en1}, 0);
        chk($sformatf("%s/wr_addr", tag), {wr_addr2, wr_addr1}, 0);
        chk($sformatf("%s/wr_data", tag), {wr_data2, wr_data1}, 0);
        chk($sformatf("%s/busy", tag), {busy2, busy1}, 0);
        chk($sformatf("%s/frame_done", tag), {fd2, fd1}, 0);
        chk($sformatf("%s/err", tag), {err2, err1}, 0);
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_dat   = 8'd0;
        cyc(2);
        chk_all_zero("reset");
        resetn = 1'b1;
        cyc(2);

        // Nominal ramp frame
        clear_mon();
        gen(4, 1'b1);
        pulse_start();
        chk("nominal/busy_arm", {busy2, busy1}, 2'b11);
        play_frame();
        check_frame("nominal", 4, 1'b0);

        // Start while a frame is already streaming
        clear_mon();
        gen(4, 1'b0);
        pulse_start();
        play_lines(0);
        chk("midframe/no_early_writes", q2d.size() + q1d.size(), 0);
        gen(4, 1'b0);
        play_frame();
        check_frame("midframe", 4, 1'b0);

        // Odd byte count on line 1
        clear_mon();
        gen(4, 1'b0);
        llen[1] = 15;
        pulse_start();
        play_frame();
        check_frame("odd", 4, 1'b0);

        // Short frame: vsync rises after two lines
        clear_mon();
        gen(2, 1'b0);
        pulse_start();
        play_frame();
        check_frame("short", 2, 1'b0);

        // Reset mid-line after err has been set
        clear_mon();
        gen(4, 1'b0);
        llen[0] = 15;
        pulse_start();
        vs_pulse();
        play_line(0);
        chk("rst/err_before", {err2, err1}, 2'b11);
        for (int b = 0; b < 5; b++) begin
            cam_href = 1'b1;
            cam_dat  = fb[1][b];
            cyc(1);
        end
        resetn = 1'b0;
        cyc(1);
        chk_all_zero("rst_mid");
        resetn   = 1'b1;
        cam_href = 1'b0;
        cam_dat  = 8'd0;
        cyc(3);
        clear_mon();
        gen(4, 1'b0);
        pulse_start();
        play_frame();
        check_frame("post_reset", 4, 1'b0);

        // Abort during capture after the first 8 bytes of line 0
        clear_mon();
        gen(4, 1'b0);
        llen[0] = 8;
        pulse_start();
        vs_pulse();
        for (int b = 0; b < 8; b++) begin
            cam_href = 1'b1;
            cam_dat  = fb[0][b];
            cyc(1);
        end
        cam_href = 1'b0;
        cam_dat  = 8'd0;
        abort    = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort/idle_next", {busy2, busy1}, 0);
        play_lines(1);
        vs_pulse();
        check_frame("abort", 1, 1'b1);

        // Abort beats start in the same cycle
        start = 1'b1;
        abort = 1'b1;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start/busy", {busy2, busy1}, 0);

        // Clean frame after abort
        clear_mon();
        gen(4, 1'b0);
        pulse_start();
        play_frame();
        check_frame("after_abort", 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Frame-grab sequencer for the OV-style parallel camera path: arms on request, locks to the next frame boundary, and assembles byte pairs into RGB565 pixels.
- Decimates by DECIM in both axes and writes the kept pixels sequentially into a scratchpad.
- Reports frame done, busy and error status.
- Sits between the IO-registered camera pins (dat/href/vsync) and the scratchpad write port; runs entirely in the camera pixel-clock domain.

Parameters:
- H_ACTIVE, 640, active pixels per line (2 bytes each).
- V_ACTIVE, 480, active lines per frame.
- DECIM, 16, keep every DECIM-th pixel and line; power of 2, ≥1.
- ADDR_W, 11, scratchpad word address width; must hold (H_ACTIVE/DECIM)*(V_ACTIVE/DECIM)-1.

Ports:
- clk  in  1  camera pixel clock; all logic rising-edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse (already synchronized into clk): arm capture of the next full frame.
- abort  in  1  one-cycle pulse: cancel capture, return to IDLE.
- cam_vsync  in  1  IO-registered vsync; high = vertical blanking.
- cam_href  in  1  IO-registered href; high = valid bytes on cam_dat.
- cam_dat  in  8  IO-registered pixel byte.
- wr_en  out  1  scratchpad write strobe.
- wr_addr  out  ADDR_W  scratchpad word address.
- wr_data  out  16  RGB565 pixel, first byte in [15:8].
- busy  out  1  high in ARM, VBLANK, CAPTURE.
- frame_done  out  1  one-cycle pulse at end of capture.
- err  out  1  sticky: short frame or odd byte count on a line; cleared by the next accepted start.

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE. wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, err=0. All counters and the byte phase = 0. Reset mid-capture aborts immediately; no further writes.
- Edge detect: vs_q/hr_q hold the previous-cycle cam_vsync/cam_href. vs_rise = vsync & ~vs_q. vs_fall = ~vsync & vs_q. hr_fall = ~href & hr_q.
- IDLE:
  - start → ARM; clear err, counters and wr_addr.
  - start while busy is ignored.
- ARM: wait for vs_rise (skips any partial frame in progress) → VBLANK.
- VBLANK: vs_fall → CAPTURE with row=0, col=0, phase=0.
- CAPTURE, per cycle with href=1:
  - phase=0: latch cam_dat into hi, phase←1.
  - phase=1: form pixel {hi, cam_dat}, phase←0.
    - If (col mod DECIM==0) and (row mod DECIM==0) and col<H_ACTIVE: next cycle wr_en=1, wr_data=pixel, wr_addr=current out pointer. The out pointer increments after each write.
    - col increments, saturating at H_ACTIVE; extra pixels are dropped without error.
- hr_fall in CAPTURE:
  - row++, col←0, phase←0.
  - If phase was 1 (odd byte count), set err and discard the partial byte.
  - If row reaches V_ACTIVE → DONE; trailing lines are ignored.
- vs_rise in CAPTURE before row==V_ACTIVE: set err, → DONE.
- Simultaneous hr_fall and vs_rise: process hr_fall first, then vs_rise in the same cycle.
- DONE: frame_done=1 for exactly one cycle, then → IDLE. busy drops in the same cycle frame_done is high.
- abort in any state → IDLE next cycle, with no frame_done. abort has priority over all other events, including start in the same cycle.
- wr_en is a one-cycle pulse, at most one every 2 clk (one per pixel). Latency is 1 clk from the second byte sample to wr_en.
- wr_addr wraps modulo 2^ADDR_W. Parameter legality makes wrap unreachable.

Decomposition:
- Shared package cam_pkg holds:
  - state enum {IDLE, ARM, VBLANK, CAPTURE, DONE};
  - constants OUT_W=H_ACTIVE/DECIM and OUT_H=V_ACTIVE/DECIM;
  - RGB565 pixel type.
- One natural sub-module: cam_byte_packer (byte phase, hi latch, pixel-valid pulse).
- Everything else (FSM, row/col counters, decimation, address pointer) stays in the top block.

Test Plan (unless noted: H_ACTIVE=8, V_ACTIVE=4, DECIM=2, ADDR_W=3):
- Nominal frame: start, vsync high 4 clk then low, 4 lines of 16 bytes (0x00..0x0F). Expect 8 writes, addr 0..7, lines 0 and 2 only. Line-0 data 0x0001, 0x0405, 0x0809, 0x0C0D. frame_done once, err=0, busy low after.
- Start mid-frame (vsync already low, href toggling): expect no writes until the next vs_rise→vs_fall. Then the full 8 writes.
- Odd line: line 1 carries 15 bytes. Expect err=1 at that hr_fall. Writes unaffected (line 1 is decimated away); frame_done still pulses.
- Short frame: vs_rise after 2 lines. Expect 4 writes (addr 0..3), err=1, frame_done pulse.
- abort during CAPTURE after 2 writes: expect IDLE next clk, no further wr_en, no frame_done. A new start then yields a clean frame with err=0 and addresses from 0.
- resetn=0 for 1 clk mid-line, then start: expect all outputs 0 during reset and normal capture afterwards. DECIM=1 variant: 32 consecutive writes with wr_en spacing exactly 2 clk.
